// File: rtl/instruction_fetch_unit.sv
// Fetch front end: issues word-aligned reads, queues returned words with their PCs,
// and hands them to decode in order; a redirect flushes the queue and drops stale responses.
module instruction_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        fetch_request_valid,
  input  logic        fetch_request_ready,
  output logic [31:0] fetch_address,
  input  logic        fetch_response_valid,
  input  logic [31:0] fetch_response_data,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        instruction_valid,
  input  logic        instruction_ready,
  output logic [31:0] instruction,
  output logic [31:0] instruction_pc
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_LIMIT = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] in_flight_next;
  logic [PW-1:0] q_wr;
  logic [PW-1:0] q_rd;
  logic [PW-1:0] p_wr;
  logic [PW-1:0] p_rd;
  logic [31:0]   q_word [DEPTH];
  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   p_pc   [DEPTH];
  logic [CW:0]   in_use;
  logic          accept;
  logic          respond;
  logic          keep;
  logic          dequeue;
  logic          unused_target_bits;

  assign unused_target_bits = ^redirect_target[1:0];

  // Credit covers both queued words and requests still in flight, so every
  // response is guaranteed a queue slot.
  assign in_use              = {1'b0, count} + {1'b0, outstanding};
  assign fetch_request_valid = !reset && (in_use < DEPTH_LIMIT);
  assign fetch_address       = fetch_pc;
  assign accept              = fetch_request_valid && fetch_request_ready;
  assign respond             = fetch_response_valid && !reset;
  assign keep                = respond && (drop == '0) && !redirect;
  assign instruction_valid   = (count != '0) && !reset;
  assign dequeue             = instruction_valid && instruction_ready;
  assign instruction         = q_word[q_rd];
  assign instruction_pc      = q_pc[q_rd];
  assign in_flight_next      = outstanding + CW'(accept) - CW'(respond);

  always_ff @(posedge clock) begin
    if (accept) begin
      p_pc[p_wr] <= fetch_pc;
    end
    if (keep) begin
      q_word[q_wr] <= fetch_response_data;
      q_pc[q_wr]   <= p_pc[p_rd];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      q_wr        <= '0;
      q_rd        <= '0;
      p_wr        <= '0;
      p_rd        <= '0;
    end else begin
      if (accept) begin
        p_wr <= p_wr + PW'(1);
      end
      if (respond) begin
        p_rd <= p_rd + PW'(1);
      end
      outstanding <= in_flight_next;
      // Every request still in flight after this edge belongs to the old path.
      if (redirect) begin
        fetch_pc <= {redirect_target[31:2], 2'b00};
        count    <= '0;
        q_wr     <= '0;
        q_rd     <= '0;
        drop     <= in_flight_next;
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (respond && (drop != '0)) begin
          drop <= drop - CW'(1);
        end
        if (keep) begin
          q_wr <= q_wr + PW'(1);
        end
        if (dequeue) begin
          q_rd <= q_rd + PW'(1);
        end
        count <= count + CW'(keep) - CW'(dequeue);
      end
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit against a queue-based model of the
// fetch path: in-flight requests carry a stale flag, delivered words form an in-order list.
module tb_instruction_fetch_unit;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock;
  logic        reset;
  logic        fetch_request_valid;
  logic        fetch_request_ready;
  logic [31:0] fetch_address;
  logic        fetch_response_valid;
  logic [31:0] fetch_response_data;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        instruction_valid;
  logic        instruction_ready;
  logic [31:0] instruction;
  logic [31:0] instruction_pc;

  instruction_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock               (clock),
    .reset               (reset),
    .fetch_request_valid (fetch_request_valid),
    .fetch_request_ready (fetch_request_ready),
    .fetch_address       (fetch_address),
    .fetch_response_valid(fetch_response_valid),
    .fetch_response_data (fetch_response_data),
    .redirect            (redirect),
    .redirect_target     (redirect_target),
    .instruction_valid   (instruction_valid),
    .instruction_ready   (instruction_ready),
    .instruction         (instruction),
    .instruction_pc      (instruction_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    bit          stale;
  } entry_t;

  entry_t      inflight [$];
  entry_t      queued   [$];
  logic [31:0] model_pc;
  int unsigned checks;
  int unsigned errors;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit hit(input int unsigned pct);
    return $urandom_range(99) < pct;
  endfunction

  function automatic logic [31:0] pick_target();
    case ($urandom_range(3))
      0:       return 32'hFFFF_FFF0 | 32'($urandom_range(3));
      1:       return 32'h0000_0103;
      default: return $urandom & 32'h0000_0FFF;
    endcase
  endfunction

  task automatic run_cycle(input int unsigned p_mem, input int unsigned p_resp,
                           input int unsigned p_cons, input int unsigned p_redir,
                           input bit rst);
    bit     exp_frv;
    bit     exp_iv;
    bit     acc;
    bit     deq;
    bit     resp;
    bit     redir;
    entry_t e;
    @(negedge clock);
    reset                = rst;
    fetch_request_ready  = hit(p_mem);
    fetch_response_valid = !rst && (inflight.size() != 0) && hit(p_resp);
    fetch_response_data  = fetch_response_valid ? inflight[0].word : $urandom;
    redirect             = !rst && hit(p_redir);
    redirect_target      = pick_target();
    instruction_ready    = hit(p_cons);
    #1;
    exp_frv = !rst && (queued.size() + inflight.size() < DEPTH);
    exp_iv  = !rst && (queued.size() != 0);
    chk("fetch_request_valid", 32'(fetch_request_valid), 32'(exp_frv));
    if (exp_frv) chk("fetch_address", fetch_address, model_pc);
    chk("instruction_valid", 32'(instruction_valid), 32'(exp_iv));
    if (exp_iv) begin
      chk("instruction_pc", instruction_pc, queued[0].pc);
      chk("instruction", instruction, queued[0].word);
    end
    acc   = fetch_request_valid && fetch_request_ready;
    deq   = instruction_valid && instruction_ready;
    resp  = fetch_response_valid;
    redir = redirect;
    @(posedge clock);
    if (rst) begin
      inflight.delete();
      queued.delete();
      model_pc = RESET_PC;
    end else begin
      if (deq && queued.size() != 0) void'(queued.pop_front());
      if (resp) begin
        e = inflight.pop_front();
        if (!e.stale && !redir) queued.push_back(e);
      end
      if (acc) begin
        inflight.push_back('{pc: model_pc, word: $urandom, stale: 1'b0});
        model_pc = model_pc + 32'd4;
      end
      if (redir) begin
        foreach (inflight[i]) inflight[i].stale = 1'b1;
        queued.delete();
        model_pc = {redirect_target[31:2], 2'b00};
      end
    end
  endtask

  initial begin
    checks               = 0;
    errors               = 0;
    model_pc             = RESET_PC;
    reset                = 1'b1;
    fetch_request_ready  = 1'b0;
    fetch_response_valid = 1'b0;
    fetch_response_data  = '0;
    redirect             = 1'b0;
    redirect_target      = '0;
    instruction_ready    = 1'b0;

    for (int i = 0; i < 3; i++) run_cycle(100, 100, 100, 0, 1'b1);
    // Full-throughput stream with an always-ready memory and consumer.
    for (int i = 0; i < 40; i++) run_cycle(100, 100, 100, 0, 1'b0);
    // Stalled consumer: credit fills, then single pops release single requests.
    for (int i = 0; i < 12; i++) run_cycle(100, 100, 0, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      run_cycle(100, 100, 100, 0, 1'b0);
      for (int i = 0; i < 4; i++) run_cycle(100, 100, 0, 0, 1'b0);
    end
    // Redirect-heavy traffic, including wrap-around and misaligned targets.
    for (int i = 0; i < 300; i++) run_cycle(100, 100, 100, 10, 1'b0);
    for (int i = 0; i < 600; i++) run_cycle(70, 60, 60, 6, 1'b0);
    // Reset landing in the middle of busy traffic.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 40; i++) run_cycle(80, 50, 30, 4, 1'b0);
      run_cycle(80, 50, 30, 0, 1'b1);
    end
    for (int i = 0; i < 200; i++) run_cycle(90, 90, 80, 3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
